// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the doubleword memory responder: FSM state codes,
// doubleword width and the alignment helper used when DMEM_ALIGN_CHECK_EN is set.
package dmem_responder_pkg;

    localparam int unsigned DWORD_W = 64;

    typedef logic [1:0]         state_t;
    typedef logic [DWORD_W-1:0] dword_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    function automatic logic is_misaligned(input logic [2:0] byte_off);
        return (byte_off != 3'd0);
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Doubleword storage for dmem_responder: synchronous write, combinational read,
// no reset so contents survive a responder reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 128,
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  dword_t           wdata,
    input  logic [IDX_W-1:0] raddr,
    output dword_t           rdata
);

    dword_t mem_q [DEPTH_WORDS];

    // Storage write port
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding doubleword load/store responder with a fixed wait-state count.
// Optional feature: define DMEM_ALIGN_CHECK_EN to add resp_err and suppress misaligned accesses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic         CLK,
    input  logic         resetl,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [63:0]  req_addr,
    input  logic [63:0]  req_wdata,
    output logic         resp_valid,
    output logic [63:0]  resp_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic         resp_err,
`endif
    output logic         busy
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [63:0] addr_q, addr_d;
    dword_t      wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        resp_valid_q, resp_valid_d;
    dword_t      resp_rdata_q, resp_rdata_d;

    logic        accept_s;
    logic        in_resp_s;
    logic        entering_resp_s;
    logic        cur_write_s;
    logic [63:0] cur_addr_s;
    dword_t      cur_wdata_s;
    logic        cur_mis_s;
    logic        lat_mis_s;
    logic        we_s;
    dword_t      rd_data_s;

    // Next-state, wait counter and request latch
    always_comb begin
        accept_s = req_valid && ready_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // With zero wait cycles RESP is entered on the acceptance edge, so the
    // store must be taken straight from the request inputs.
    // Store commit on the RESP-entry edge
    always_comb begin
        in_resp_s       = (state_q == ST_RESP);
        entering_resp_s = (state_d == ST_RESP) && !in_resp_s;
        if (state_q == ST_IDLE) begin
            cur_write_s = req_write;
            cur_addr_s  = req_addr;
            cur_wdata_s = req_wdata;
        end else begin
            cur_write_s = write_q;
            cur_addr_s  = addr_q;
            cur_wdata_s = wdata_q;
        end
`ifdef DMEM_ALIGN_CHECK_EN
        cur_mis_s = is_misaligned(cur_addr_s[2:0]);
        lat_mis_s = is_misaligned(addr_q[2:0]);
`else
        cur_mis_s = 1'b0;
        lat_mis_s = 1'b0;
`endif
        we_s = entering_resp_s && cur_write_s && !cur_mis_s;
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .CLK   (CLK),
        .we    (we_s),
        .waddr (cur_addr_s[IDX_W+2:3]),
        .wdata (cur_wdata_s),
        .raddr (addr_q[IDX_W+2:3]),
        .rdata (rd_data_s)
    );

    // Registered outputs; ready stays low through the response pulse
    always_comb begin
        resp_valid_d = in_resp_s;
        if (in_resp_s && !write_q && !lat_mis_s) begin
            resp_rdata_d = rd_data_s;
        end else begin
            resp_rdata_d = 64'd0;
        end
        busy_d  = (state_d != ST_IDLE) || in_resp_s;
        ready_d = (state_d == ST_IDLE) && !in_resp_s;
    end

    // Control and request state
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Output registers
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
        end else begin
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic resp_err_q, resp_err_d;

    // Misalignment flag accompanies the response pulse
    always_comb begin
        resp_err_d = in_resp_s && lat_mis_s;
    end

    // Error flag register
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            resp_err_q <= 1'b0;
        end else begin
            resp_err_q <= resp_err_d;
        end
    end

    assign resp_err = resp_err_q;
`endif

    assign req_ready  = ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench: two responders (2 and 0 wait cycles) share one
// request stream and are compared against a plain array-based reference model.
module tb_dmem_responder;

    logic        CLK;
    logic        resetl;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        ready_a, valid_a, busy_a;
    logic [63:0] rdata_a;
    logic        ready_b, valid_b, busy_b;
    logic [63:0] rdata_b;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        err_a, err_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] mem_a [128];
    logic [63:0] mem_b [128];

    dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(2)) u_dut_a (
        .CLK(CLK), .resetl(resetl), .req_valid(req_valid), .req_ready(ready_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(valid_a), .resp_rdata(rdata_a),
`ifdef DMEM_ALIGN_CHECK_EN
        .resp_err(err_a),
`endif
        .busy(busy_a)
    );

    dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) u_dut_b (
        .CLK(CLK), .resetl(resetl), .req_valid(req_valid), .req_ready(ready_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(valid_b), .resp_rdata(rdata_b),
`ifdef DMEM_ALIGN_CHECK_EN
        .resp_err(err_b),
`endif
        .busy(busy_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned word_of(input logic [63:0] addr);
        return int'((addr / 64'd8) % 64'd128);
    endfunction

    function automatic bit misaligned(input logic [63:0] addr);
`ifdef DMEM_ALIGN_CHECK_EN
        return (addr % 64'd8) != 64'd0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic scramble_inputs();
        req_write = 1'($urandom_range(0, 1));
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic wait_ready();
        int guard = 0;
        @(negedge CLK);
        while (!(ready_a && ready_b) && guard < 40) begin
            @(negedge CLK);
            guard++;
        end
        check_eq("ready_wait", {62'd0, ready_a, ready_b}, 64'd3);
    endtask

    // One isolated request; c counts cycles after the acceptance edge.
    task automatic do_req(input bit wr, input logic [63:0] addr, input logic [63:0] wd);
        int unsigned idx;
        bit          mis;
        logic [63:0] exp_a, exp_b;
        idx   = word_of(addr);
        mis   = misaligned(addr);
        exp_a = (wr || mis) ? 64'd0 : mem_a[idx];
        exp_b = (wr || mis) ? 64'd0 : mem_b[idx];
        if (wr && !mis) begin
            mem_a[idx] = wd;
            mem_b[idx] = wd;
        end
        wait_ready();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge CLK);
        req_valid = 1'b0;
        scramble_inputs();
        for (int c = 0; c < 6; c++) begin
            check_eq("a_valid", valid_a, c == 3);
            check_eq("a_rdata", rdata_a, (c == 3) ? exp_a : 64'd0);
            check_eq("a_ready", ready_a, c >= 4);
            check_eq("a_busy",  busy_a,  c <= 3);
            check_eq("b_valid", valid_b, c == 1);
            check_eq("b_rdata", rdata_b, (c == 1) ? exp_b : 64'd0);
            check_eq("b_ready", ready_b, c >= 2);
            check_eq("b_busy",  busy_b,  c <= 1);
`ifdef DMEM_ALIGN_CHECK_EN
            check_eq("a_err", err_a, (c == 3) && mis);
            check_eq("b_err", err_b, (c == 1) && mis);
`endif
            @(negedge CLK);
        end
    endtask

    // Two loads with req_valid held: second accepted only once ready returns.
    task automatic back_to_back(input logic [63:0] addr);
        logic [63:0] exp_a;
        exp_a = misaligned(addr) ? 64'd0 : mem_a[word_of(addr)];
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        req_wdata = 64'd0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (c == 5) req_valid = 1'b0;
            check_eq("b2b_valid", valid_a, (c == 3) || (c == 8));
            check_eq("b2b_rdata", rdata_a, ((c == 3) || (c == 8)) ? exp_a : 64'd0);
            check_eq("b2b_ready", ready_a, (c == 4) || (c == 9));
            check_eq("b2b_busy",  busy_a,  !((c == 4) || (c == 9)));
        end
    endtask

    task automatic reset_mid_store();
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h8;
        req_wdata = 64'h55;
        @(negedge CLK);
        req_valid = 1'b0;
        mem_b[1]  = 64'h55;
        check_eq("rst_in_wait_busy", busy_a, 1'b1);
        resetl = 1'b0;
        #1;
        check_eq("rst_valid", valid_a, 1'b0);
        check_eq("rst_ready", ready_a, 1'b0);
        check_eq("rst_busy",  busy_a,  1'b0);
        @(negedge CLK);
        resetl = 1'b1;
        @(negedge CLK);
        check_eq("rst_release_ready_a", ready_a, 1'b1);
        check_eq("rst_release_ready_b", ready_b, 1'b1);
        for (int c = 0; c < 4; c++) begin
            check_eq("aborted_no_valid", valid_a, 1'b0);
            @(negedge CLK);
        end
        do_req(1'b0, 64'h8, 64'd0);
    endtask

    initial begin
        resetl    = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 64'd0;
        req_wdata = 64'd0;
        repeat (3) @(negedge CLK);
        check_eq("reset_valid_a", valid_a, 1'b0);
        check_eq("reset_rdata_a", rdata_a, 64'd0);
        check_eq("reset_ready_a", ready_a, 1'b0);
        check_eq("reset_busy_a",  busy_a,  1'b0);
        check_eq("reset_ready_b", ready_b, 1'b0);
        check_eq("reset_valid_b", valid_b, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
        check_eq("reset_err_a", err_a, 1'b0);
`endif
        resetl = 1'b1;
        @(negedge CLK);
        check_eq("post_reset_ready_a", ready_a, 1'b1);

        for (int i = 0; i < 128; i++) begin
            do_req(1'b1, 64'(i) * 64'd8, {$urandom, $urandom});
        end

        do_req(1'b1, 64'h40, 64'h0123456789ABCDEF);
        do_req(1'b0, 64'h40, 64'd0);
        do_req(1'b1, 64'h400, 64'hAA);
        do_req(1'b0, 64'h0, 64'd0);
        back_to_back(64'h40);
        reset_mid_store();
`ifdef DMEM_ALIGN_CHECK_EN
        do_req(1'b1, 64'h13, 64'hDEAD_BEEF_0000_0001);
        do_req(1'b0, 64'h10, 64'd0);
`endif

        for (int i = 0; i < 200; i++) begin
            do_req(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
